// File: rtl/el2_lsu_ecc_corr_if.sv
// DCCM ECC correction engine bus: decoder results in, correction
// writes and scrub reads out.
interface el2_lsu_ecc_corr_if #(
  parameter int NUM_BANKS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                            det_valid;
  logic [ADDR_WIDTH-1:0]           det_addr;
  logic [NUM_BANKS-1:0]            det_single;
  logic [NUM_BANKS-1:0]            det_double;
  logic [NUM_BANKS*DATA_WIDTH-1:0] det_data;
  logic                            wr_req;
  logic                            wr_gnt;
  logic [ADDR_WIDTH-1:0]           wr_addr;
  logic [DATA_WIDTH-1:0]           wr_data;
  logic                            rd_req;
  logic                            rd_gnt;
  logic [ADDR_WIDTH-1:0]           rd_addr;

  modport master (
    input  det_valid, det_addr, det_single, det_double, det_data,
    input  wr_gnt, rd_gnt,
    output wr_req, wr_addr, wr_data, rd_req, rd_addr
  );

  modport slave (
    output det_valid, det_addr, det_single, det_double, det_data,
    output wr_gnt, rd_gnt,
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr
  );
endinterface

// File: rtl/el2_lsu_ecc_corr.sv
// DCCM ECC correction-writeback engine with coalescing FIFO and SEC/DED counters.
// Define RV_LSU_ECC_SCRUB_EN to include the background scrubber.
module el2_lsu_ecc_corr #(
  parameter int NUM_BANKS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] SCRUB_LAST = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ecc_disable,
  el2_lsu_ecc_corr_if.master   bus,
  output logic                 fifo_ovf,
  output logic [CNT_WIDTH-1:0] sec_count,
  output logic [CNT_WIDTH-1:0] ded_count,
  input  logic [CNT_WIDTH-1:0] thresh,
  input  logic                 cnt_clr,
  output logic                 err_irq,
  input  logic [CNT_WIDTH-1:0] scrub_interval
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [CNT_WIDTH:0]    cntx_t;
  typedef struct packed {
    addr_t addr;
    data_t data;
  } ent_t;

  typedef enum logic {WR_IDLE, WR_REQ} wr_st_t;

  ent_t                 fifo_q [FIFO_DEPTH];
  ent_t                 fifo_d [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  wr_st_t               wr_st_q, wr_st_d;
  logic                 cap, pop, drop;
  int                   nsec, nded;
  logic [CNT_WIDTH-1:0] sec_d, ded_d;
  logic                 ovf_d, irq_d;

  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] a,
    input int                   n
  );
    cntx_t s;
    s = {1'b0, a} + cntx_t'(n);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  assign cap = bus.det_valid & ~ecc_disable;
  assign pop = bus.wr_req & bus.wr_gnt;

  always_comb begin : fifo_upd
    logic [PW-1:0] j;
    logic          hit;
    addr_t         ea;
    data_t         ed;
    int            free;
    int            npush;
    fifo_d = fifo_q;
    nsec   = 0;
    nded   = 0;
    drop   = 1'b0;
    j      = '0;
    hit    = 1'b0;
    ea     = '0;
    ed     = '0;
    npush  = 0;
    free   = FIFO_DEPTH - int'(cnt_q) + int'(pop);
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (cap && bus.det_double[b]) nded++;
      if (cap && bus.det_single[b] && !bus.det_double[b]) begin
        nsec++;
        ea  = bus.det_addr + addr_t'(b);
        ed  = bus.det_data[b*DATA_WIDTH +: DATA_WIDTH];
        hit = 1'b0;
        // A head being granted this cycle is gone; its address re-queues.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          j = rd_ptr_q + PW'(i);
          if (i < int'(cnt_q) && fifo_q[j].addr == ea &&
              (i != 0 || !pop)) begin
            fifo_d[j].data = ed;
            hit = 1'b1;
          end
        end
        if (!hit) begin
          if (npush < free) begin
            j = wr_ptr_q + PW'(npush);
            fifo_d[j] = '{addr: ea, data: ed};
            npush++;
          end else begin
            drop = 1'b1;
          end
        end
      end
    end
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(npush);
    cnt_d    = CW'(int'(cnt_q) - int'(pop) + npush);
  end

  always_comb begin
    sec_d = sec_count;
    ded_d = ded_count;
    ovf_d = fifo_ovf;
    irq_d = err_irq;
    if (cnt_clr) begin
      sec_d = '0;
      ded_d = '0;
      ovf_d = 1'b0;
      irq_d = 1'b0;
    end else begin
      sec_d = sat_add(sec_count, nsec);
      ded_d = sat_add(ded_count, nded);
      ovf_d = fifo_ovf | drop;
      irq_d = err_irq | ((thresh != '0) && (sec_d >= thresh)) |
              (ded_d != '0);
    end
  end

  always_comb begin
    wr_st_d = wr_st_q;
    unique case (wr_st_q)
      WR_IDLE: if (cnt_d != '0) wr_st_d = WR_REQ;
      WR_REQ:  if (pop && cnt_d == '0) wr_st_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      wr_st_q   <= WR_IDLE;
      sec_count <= '0;
      ded_count <= '0;
      fifo_ovf  <= 1'b0;
      err_irq   <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      wr_st_q   <= wr_st_d;
      sec_count <= sec_d;
      ded_count <= ded_d;
      fifo_ovf  <= ovf_d;
      err_irq   <= irq_d;
    end
  end

  assign bus.wr_req  = (wr_st_q == WR_REQ);
  assign bus.wr_addr = bus.wr_req ? fifo_q[rd_ptr_q].addr : '0;
  assign bus.wr_data = bus.wr_req ? fifo_q[rd_ptr_q].data : '0;

`ifdef RV_LSU_ECC_SCRUB_EN
  typedef enum logic {SC_WAIT, SC_REQ} sc_st_t;

  localparam logic [ADDR_WIDTH:0] LAST_X = {1'b0, SCRUB_LAST};

  sc_st_t                sc_st_q, sc_st_d;
  logic [CNT_WIDTH-1:0]  sc_cnt_q, sc_cnt_d;
  addr_t                 sc_addr_q, sc_addr_d;
  logic [ADDR_WIDTH:0]   sc_nxt;
  logic                  sc_stall;

  // Corrections take priority over scrubbing the next word.
  assign sc_stall = (cnt_q != '0) | ecc_disable;
  assign sc_nxt   = {1'b0, sc_addr_q} + (ADDR_WIDTH+1)'(NUM_BANKS);

  always_comb begin
    sc_st_d   = sc_st_q;
    sc_cnt_d  = sc_cnt_q;
    sc_addr_d = sc_addr_q;
    unique case (sc_st_q)
      SC_WAIT: begin
        if (!sc_stall) begin
          if (sc_cnt_q >= scrub_interval) begin
            sc_st_d  = SC_REQ;
            sc_cnt_d = '0;
          end else begin
            sc_cnt_d = sc_cnt_q + 1'b1;
          end
        end
      end
      SC_REQ: begin
        if (bus.rd_gnt) begin
          sc_st_d   = SC_WAIT;
          sc_addr_d = (sc_nxt > LAST_X) ? '0 : sc_nxt[ADDR_WIDTH-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_st_q   <= SC_WAIT;
      sc_cnt_q  <= '0;
      sc_addr_q <= '0;
    end else begin
      sc_st_q   <= sc_st_d;
      sc_cnt_q  <= sc_cnt_d;
      sc_addr_q <= sc_addr_d;
    end
  end

  assign bus.rd_req  = (sc_st_q == SC_REQ);
  assign bus.rd_addr = sc_addr_q;
`else
  logic unused_scrub;
  assign unused_scrub = ^{bus.rd_gnt, scrub_interval, SCRUB_LAST};
  assign bus.rd_req   = 1'b0;
  assign bus.rd_addr  = '0;
`endif

endmodule

// File: doc/el2_lsu_ecc_corr.md
# el2_lsu_ecc_corr

Parametrised DCCM ECC correction-writeback engine for the LSU, sitting after the R-stage ECC decoders. Takes per-bank single/double error flags plus corrected data for N banks, queues the single-bit corrections in a coalescing FIFO, and replays them to the DCCM write port through a request/grant handshake. Keeps saturating SEC/DED counters with a threshold interrupt. Optionally includes a background scrubber that walks DCCM words through the normal read path.

## Interface
- NUM_BANKS, 2, banks checked per access (1..4)
- DATA_WIDTH, 32, data bits per bank
- ADDR_WIDTH, 16, DCCM word-address width
- FIFO_DEPTH, 4, correction FIFO entries (power of 2, ≥ NUM_BANKS)
- CNT_WIDTH, 16, error counter width
- SCRUB_LAST, 16'hFFFF, last scrub word address
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ecc_disable  in  1  suppresses queueing, counting, scrubbing
- det_valid  in  1  decoder result valid this cycle
- det_addr  in  ADDR_WIDTH  word address of bank 0; bank b is det_addr+b
- det_single  in  NUM_BANKS  per-bank single-bit error
- det_double  in  NUM_BANKS  per-bank double-bit error
- det_data  in  NUM_BANKS*DATA_WIDTH  corrected data, bank b at [b*DATA_WIDTH +: DATA_WIDTH]
- wr_req  out  1  correction write request
- wr_gnt  in  1  write port grant
- wr_addr  out  ADDR_WIDTH  correction word address
- wr_data  out  DATA_WIDTH  corrected data (ECC encoded downstream)
- fifo_ovf  out  1  sticky: a correction was dropped
- sec_count  out  CNT_WIDTH  single-error count
- ded_count  out  CNT_WIDTH  double-error count
- thresh  in  CNT_WIDTH  SEC interrupt threshold; 0 disables
- cnt_clr  in  1  clears counters, fifo_ovf, err_irq
- err_irq  out  1  level interrupt
- rd_req  out  1  scrub read request
- rd_gnt  in  1  scrub read grant
- rd_addr  out  ADDR_WIDTH  scrub read address
- scrub_interval  in  CNT_WIDTH  idle cycles between scrub reads

## Operation
- Capture: on det_valid & ~ecc_disable, every bank b with det_single[b] & ~det_double[b] becomes entry {det_addr+b, data_b}, processed in ascending b.
- Coalescing: entry whose address matches a valid FIFO entry other than the head while wr_req is outstanding overwrites that entry's data; no push. Match on the head overwrites head data only if wr_gnt is low that cycle.
- Push: remaining entries pushed in bank order up to free slots (free slots counted after this cycle's pop). Excess entries dropped, fifo_ovf set.
- Pop: wr_req & wr_gnt removes head.
- Write FSM: IDLE (wr_req=0) → REQ when FIFO non-empty. REQ: wr_req=1, wr_addr/wr_data = head, stable until grant. On grant → REQ if another entry remains, else IDLE.
- Counters: sec_count += popcount(det_single & ~det_double); ded_count += popcount(det_double); both saturate at all-ones; dropped entries still counted.
- err_irq sets when (thresh≠0 & sec_count ≥ thresh) or ded_count≠0 after update; holds until cnt_clr.
- cnt_clr wins over same-cycle increments (those events discarded); FIFO unaffected.

## Timing
- Reset: wr_req=0, wr_addr=0, wr_data=0, fifo_ovf=0, counters=0, err_irq=0, rd_req=0, rd_addr=0, FIFO empty, FSMs idle. Reset mid-handshake drops wr_req/rd_req immediately; queued corrections lost.
- det_valid at cycle N → entry visible, wr_req=1 at N+1; earliest pop at N+1.
- Counters and err_irq reflect cycle-N events at N+1.
- Full FIFO with simultaneous pop: one slot available for cycle-N pushes.
- ecc_disable asserted with FIFO non-empty: queued entries still drain.

## Configuration
- RV_LSU_ECC_SCRUB_EN defined: scrub FSM SC_WAIT (count scrub_interval cycles) → SC_REQ (rd_req=1, rd_addr held until rd_gnt) → rd_addr += NUM_BANKS, wrapping to 0 past SCRUB_LAST → SC_WAIT. Counter stalls while FIFO non-empty or ecc_disable. Results return via det_* path.
- Not defined: rd_req and rd_addr tied 0; rd_gnt and scrub_interval ignored; no scrub state.

## Test plan
- Single bank 1 error, det_addr=0x10, data 0xDEADBEEF, wr_gnt=1 → wr_req at N+1, wr_addr=0x11, wr_data=0xDEADBEEF, sec_count=1, FIFO empty at N+2.
- wr_gnt=0, five distinct singles into depth 4 → four queued, fifo_ovf=1, sec_count=5; grants drain in arrival order.
- Same address 0x20 corrected twice while queued behind another entry → one write with latest data.
- Bank0 double, bank1 single → only bank 1 queued, ded_count=1, err_irq=1 at N+1; cnt_clr → all zero.
- thresh=3, three singles → err_irq at cycle after third; counter preset to all-ones stays saturated.
- With RV_LSU_ECC_SCRUB_EN, scrub_interval=2, rd_gnt=1 → rd_req every 4th cycle, rd_addr 0,2,4…, wraps to 0 after SCRUB_LAST; assert rst mid-REQ → rd_req=0 same cycle.
